// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format, receiver states and baud divisor lookup.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        PARITY_ODD = 1'b0;
    localparam logic        STOP_LEVEL = 1'b1;

    localparam int unsigned BAUD_300    = 300;
    localparam int unsigned BAUD_1200   = 1200;
    localparam int unsigned BAUD_4800   = 4800;
    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_19200  = 19200;
    localparam int unsigned BAUD_38400  = 38400;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Rounded clocks per sample tick; only ever called with constant arguments.
    function automatic logic [31:0] baud_divisor(input logic [2:0] sel,
                                                 input int unsigned clk_hz,
                                                 input int unsigned oversample);
        int unsigned baud;
        int unsigned den;
        case (sel)
            3'd0:    baud = BAUD_300;
            3'd1:    baud = BAUD_1200;
            3'd2:    baud = BAUD_4800;
            3'd3:    baud = BAUD_9600;
            3'd4:    baud = BAUD_19200;
            3'd5:    baud = BAUD_38400;
            3'd6:    baud = BAUD_57600;
            default: baud = BAUD_115200;
        endcase
        den = oversample * baud;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_receiver_baud_controller.sv
// Oversampling tick generator: one-cycle sample_ENABLE every divisor clocks, restartable by clear.
module baud_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       clear,
    output logic       sample_ENABLE
);

    logic [31:0] div_table [8];
    logic [31:0] cnt_reg;
    logic [31:0] div_last;

    // Divisors are folded to constants at elaboration; only a mux remains.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_div
            assign div_table[gi] = baud_divisor(3'(gi), CLK_HZ, OVERSAMPLE);
        end
    endgenerate

    assign div_last      = div_table[baud_select] - 32'd1;
    assign sample_ENABLE = (cnt_reg == div_last) && !clear;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear || sample_ENABLE) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 32'd1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8E1 frames, 16x oversampling. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    rx_state_t   state_reg, state_next;
    logic        rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
    logic [1:0]  sync_ok_reg;
    logic [2:0]  baud_reg;
    logic [3:0]  tick_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shadow_reg;
    logic        parity_bad_reg;
    logic        tick, decide, bit_value;
    logic        start_det, shift_en, parity_en, finish;

    baud_controller #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clock         (clock),
        .reset         (reset),
        .baud_select   (baud_reg),
        .clear         (start_det),
        .sample_ENABLE (tick)
    );

    // rxd_prev only reports a real line value once the synchronizer has flushed its reset state,
    // so a line that is already low when reset releases never looks like a start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxd_meta_reg <= 1'b1;
            rxd_sync_reg <= 1'b1;
            rxd_prev_reg <= 1'b0;
            sync_ok_reg  <= 2'b00;
        end else begin
            rxd_meta_reg <= RxD;
            rxd_sync_reg <= rxd_meta_reg;
            rxd_prev_reg <= sync_ok_reg[1] ? rxd_sync_reg : 1'b0;
            sync_ok_reg  <= {sync_ok_reg[0], 1'b1};
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            early_reg <= 2'b11;
        end else if (tick && (tick_cnt_reg == 4'd6 || tick_cnt_reg == 4'd7)) begin
            early_reg <= {early_reg[0], rxd_sync_reg};
        end
    end

    assign decide    = tick && (tick_cnt_reg == 4'd8);
    assign bit_value = (early_reg[1] & early_reg[0]) | (early_reg[1] & rxd_sync_reg) |
                       (early_reg[0] & rxd_sync_reg);
`else
    assign decide    = tick && (tick_cnt_reg == 4'd7);
    assign bit_value = rxd_sync_reg;
`endif

    always_comb begin
        state_next = state_reg;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        parity_en  = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rxd_prev_reg && !rxd_sync_reg) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (decide) state_next = bit_value ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_cnt_reg == 3'(DATA_BITS - 1)) state_next = PARITY;
                end
            end
            PARITY: begin
                if (decide) begin
                    parity_en  = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!Rx_EN) begin
            state_next = IDLE;
            start_det  = 1'b0;
            shift_en   = 1'b0;
            parity_en  = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            baud_reg       <= 3'd0;
            tick_cnt_reg   <= 4'd0;
            bit_cnt_reg    <= 3'd0;
            shadow_reg     <= 8'h00;
            parity_bad_reg <= 1'b0;
            Rx_DATA        <= 8'h00;
            Rx_VALID       <= 1'b0;
            Rx_PERROR      <= 1'b0;
            Rx_FERROR      <= 1'b0;
        end else begin
            state_reg <= state_next;
            Rx_VALID  <= 1'b0;
            if (start_det) begin
                baud_reg       <= baud_select;
                tick_cnt_reg   <= 4'd0;
                bit_cnt_reg    <= 3'd0;
                parity_bad_reg <= 1'b0;
                Rx_PERROR      <= 1'b0;
                Rx_FERROR      <= 1'b0;
            end else if (tick) begin
                tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end
            if (shift_en) begin
                shadow_reg  <= {bit_value, shadow_reg[7:1]};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            if (parity_en) begin
                parity_bad_reg <= (^shadow_reg) ^ bit_value ^ PARITY_ODD;
            end
            if (finish) begin
                Rx_PERROR <= parity_bad_reg;
                Rx_FERROR <= (bit_value != STOP_LEVEL);
                if (bit_value == STOP_LEVEL && !parity_bad_reg) begin
                    Rx_DATA  <= shadow_reg;
                    Rx_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receiving end of the link driven by the team's UART transmitter. It deserializes 11-bit frames (start, 8 data LSB-first, even parity, stop), checks the frame, and presents the byte with a one-cycle valid strobe. It sits between the RxD line and the 7-segment decoding path inside the total encoding/decoding top level, with a 50 MHz system clock.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; sets baud divisor constants
- OVERSAMPLE, 16, sample ticks per bit
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- baud_select  in  3  000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud
- Rx_EN  in  1  receiver enable
- RxD  in  1  serial line; idle high; asynchronous to clock
- Rx_DATA  out  8  last correctly received byte
- Rx_VALID  out  1  one-cycle pulse when Rx_DATA updates
- Rx_PERROR  out  1  parity error on last frame
- Rx_FERROR  out  1  framing error (stop bit low) on last frame

## Operation
- RxD always passes through a 2-flop synchronizer (reset value 1) before any use.
- Sample tick: divisor = round(CLK_HZ/(16·baud)): 10417, 2604, 651, 326, 163, 81, 54, 27 for codes 000..111. The tick counter is cleared at start detection, so sampling is phase-aligned to the frame.
- baud_select is latched at start detection; changes mid-frame take effect on the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: the synchronized RxD goes from 1 to 0 with Rx_EN=1 → START. On this transition, clear Rx_PERROR/Rx_FERROR and the tick and bit counters.
- START: at tick 8, sample the line. If 0 → DATA. If 1, treat it as a glitch → IDLE with no flags.
- DATA: sample every 16 ticks and shift into Rx_DATA's shadow register LSB-first. After 8 bits → PARITY.
- PARITY: sample the parity bit. The frame fails parity if XOR(data, parity) ≠ 0 (even parity) → STOP.
- STOP: sample the stop bit and go to IDLE in the same cycle. Outcomes:
  - Stop=1 and parity good: Rx_DATA ← shadow, Rx_VALID=1 for one cycle.
  - Stop=0: Rx_FERROR=1.
  - Parity bad: Rx_PERROR=1.
  - Both errors can be set together. On any error, Rx_DATA keeps its old value and there is no VALID.
- Error flags stay set until the next start detection or reset.
- Rx_EN=0 forces IDLE synchronously. A frame in progress is dropped with no VALID and no flags. Rx_DATA and the flags hold their values.

## Timing
- Reset values: Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, state IDLE.
- Ticks are counted from start detection. Start is sampled at tick 8, data bit i at 8+16(i+1), parity at 152, stop at 168.
- Rx_VALID and the flags are registered and rise one clock after the tick-168 sample.
- At 115200 baud this is ≈168·27+3 ≈ 4539 clocks after the falling edge reaches the pin (2 synchronizer + detect + output register).
- The receiver returns to IDLE at mid-stop. A start edge arriving 8 ticks later (back-to-back frames) is detected.
- Reset asserted mid-frame aborts immediately and all outputs return to reset values. After release, the receiver waits for a fresh high→low edge, so a line already low is not taken as a start.

## Configuration
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at ticks 7, 8, 9 of the bit. The decision is still registered at tick 9 of the start bit, and at tick 169 for the stop bit, so Rx_VALID moves one tick later.
- Undefined: a single sample at tick 8, with the timing stated above.

## Structure
- Package uart_pkg:
  - baud divisor constants and a function mapping baud_select to divisor
  - the receiver state enum
  - the frame constants: 8 data bits, even parity, 1 stop bit
- Sub-module baud_controller:
  - inputs: clock, reset, baud_select, clear
  - output: one-cycle sample_ENABLE tick at 16× baud
  - shared with the transmitter, which divides its tick by 16

## Test plan
- 115200 baud, frame 0x17 with parity 0 and stop 1 → Rx_DATA=0x17, one-cycle Rx_VALID, both flags 0.
- Frame 0xA8 with parity forced to 0 (correct value is 1) → Rx_PERROR=1, no VALID, Rx_DATA unchanged; flag clears at the next start edge.
- Frame 0x55 with stop bit 0 → Rx_FERROR=1, no VALID.
- 60 ns low glitch on idle RxD → no VALID, no flags, back in IDLE.
- Back-to-back frames 0xA8 then 0x17 with no idle gap → two VALID pulses one frame apart, data 0xA8 then 0x17.
- Reset pulsed low during the data bits of frame 0x17, then a clean frame 0x3C → outputs at reset values, then Rx_DATA=0x3C with VALID.
